// File: rtl/dpdm_pkg.sv
// Shared types and default packet lengths for the USB D+/D- line transmitter.
package dpdm_pkg;

  typedef enum logic [1:0] {
    PktNone  = 2'b00,
    PktToken = 2'b01,
    PktData  = 2'b10,
    PktHs    = 2'b11
  } pkt_type_e;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StSe0,
    StEopJ
  } state_e;

  localparam int unsigned TokBitsDef  = 32;
  localparam int unsigned DataBitsDef = 92;
  localparam int unsigned HsBitsDef   = 12;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dpdm_tx_fsm.sv
// Packet sequencer: IDLE -> DATA (LIM bits) -> SE0 -> EOPJ -> IDLE, with a non-wrapping
// phase counter.
module dpdm_tx_fsm
  import dpdm_pkg::*;
#(
  parameter int unsigned TOK_BITS  = TokBitsDef,
  parameter int unsigned DATA_BITS = DataBitsDef,
  parameter int unsigned HS_BITS   = HsBitsDef,
  parameter int unsigned EOP_SE0   = 2,
  parameter int unsigned EOP_J     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] pkt_type,
  output state_e     state,
  output logic       bit_req,
  output logic       last_j
);

  localparam int unsigned MaxLen = max_u(max_u(max_u(TOK_BITS, DATA_BITS),
                                               max_u(HS_BITS, EOP_SE0)), EOP_J);
  localparam int unsigned CntW   = $clog2(MaxLen + 1);

  if (TOK_BITS == 0 || DATA_BITS == 0 || HS_BITS == 0 || EOP_SE0 == 0 || EOP_J == 0)
  begin : g_param_check
    $error("dpdm_tx_fsm: all length parameters must be >= 1");
  end

  // Limits are held as last-index values so the counter only ever counts up to them.
  localparam logic [CntW-1:0] TokLast  = CntW'(TOK_BITS - 1);
  localparam logic [CntW-1:0] DataLast = CntW'(DATA_BITS - 1);
  localparam logic [CntW-1:0] HsLast   = CntW'(HS_BITS - 1);
  localparam logic [CntW-1:0] Se0Last  = CntW'(EOP_SE0 - 1);
  localparam logic [CntW-1:0] JLast    = CntW'(EOP_J - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   lim_q, lim_d;
  logic [CntW-1:0]   lim_sel;

  always_comb begin
    lim_sel = TokLast;
    case (pkt_type_e'(pkt_type))
      PktData: lim_sel = DataLast;
      PktHs:   lim_sel = HsLast;
      default: lim_sel = TokLast;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    bit_req = 1'b0;
    last_j  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && (pkt_type_e'(pkt_type) != PktNone)) begin
          state_d = StData;
          cnt_d   = '0;
          lim_d   = lim_sel;
        end
      end
      StData: begin
        bit_req = 1'b1;
        if (cnt_q == lim_q) begin
          state_d = StSe0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StSe0: begin
        if (cnt_q == Se0Last) begin
          state_d = StEopJ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StEopJ: begin
        if (cnt_q == JLast) begin
          last_j  = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/dpdm_tx.sv
// USB D+/D- packet transmitter with registered line pair; define DPDM_NRZI_EN to NRZI-encode
// the data bits (0 toggles the line, 1 holds it).
module dpdm_tx
  import dpdm_pkg::*;
#(
  parameter int unsigned TOK_BITS  = TokBitsDef,
  parameter int unsigned DATA_BITS = DataBitsDef,
  parameter int unsigned HS_BITS   = HsBitsDef,
  parameter int unsigned EOP_SE0   = 2,
  parameter int unsigned EOP_J     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] pkt_type,
  input  logic       bit_in,
  output logic       bit_req,
  output logic       busy,
  output logic       done,
  output logic       dp,
  output logic       dm
);

  state_e state;
  logic   last_j;
  logic   dp_d, dm_d;

  dpdm_tx_fsm #(
    .TOK_BITS  (TOK_BITS),
    .DATA_BITS (DATA_BITS),
    .HS_BITS   (HS_BITS),
    .EOP_SE0   (EOP_SE0),
    .EOP_J     (EOP_J)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pkt_type (pkt_type),
    .state    (state),
    .bit_req  (bit_req),
    .last_j   (last_j)
  );

  // Line, busy and done are all registered from the same FSM cycle, so they stay aligned
  // with each other one cycle behind the state.
  always_comb begin
    dp_d = 1'b1;
    dm_d = 1'b0;
    unique case (state)
      StData: begin
`ifdef DPDM_NRZI_EN
        // The line is always J on entry to DATA, so each packet starts NRZI from J.
        dp_d = bit_in ? dp : ~dp;
`else
        dp_d = bit_in;
`endif
        dm_d = ~dp_d;
      end
      StSe0: begin
        dp_d = 1'b0;
        dm_d = 1'b0;
      end
      StIdle, StEopJ: begin
        dp_d = 1'b1;
        dm_d = 1'b0;
      end
      default: begin
        dp_d = 1'b1;
        dm_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp   <= 1'b1;
      dm   <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      dp   <= dp_d;
      dm   <= dm_d;
      busy <= (state != StIdle);
      done <= last_j;
    end
  end

endmodule

// File: tb/tb_dpdm_tx.sv
// Scoreboard bench for dpdm_tx: default instance plus one with a 3-cycle SE0 and 4-cycle J.
module tb_dpdm_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start    [2];
  logic [1:0] pkt_type [2];
  logic       bit_in   [2];
  logic       bit_req  [2];
  logic       busy     [2];
  logic       done     [2];
  logic       dp       [2];
  logic       dm       [2];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Entry: {last_of_packet, dp, dm, done}
  logic [3:0] q0 [$];
  logic [3:0] q1 [$];

  always #5 clk = ~clk;

  dpdm_tx u_dut0 (
    .clk      (clk),
    .rst      (rst),
    .start    (start[0]),
    .pkt_type (pkt_type[0]),
    .bit_in   (bit_in[0]),
    .bit_req  (bit_req[0]),
    .busy     (busy[0]),
    .done     (done[0]),
    .dp       (dp[0]),
    .dm       (dm[0])
  );

  dpdm_tx #(
    .EOP_SE0 (3),
    .EOP_J   (4)
  ) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .start    (start[1]),
    .pkt_type (pkt_type[1]),
    .bit_in   (bit_in[1]),
    .bit_req  (bit_req[1]),
    .busy     (busy[1]),
    .done     (done[1]),
    .dp       (dp[1]),
    .dm       (dm[1])
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  function automatic void push(input int k, input logic [3:0] v);
    if (k == 0) q0.push_back(v);
    else q1.push_back(v);
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [3:0] pop(input int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic int pkt_len(input logic [1:0] pt);
    case (pt)
      2'b01:   return 32;
      2'b10:   return 92;
      default: return 12;
    endcase
  endfunction

  // Monitor: every busy cycle must match the next expected line symbol.
  logic       busy_prev [2] = '{1'b0, 1'b0};
  logic       last_pop  [2] = '{1'b0, 1'b0};
  always @(negedge clk) begin
    logic [3:0] e;
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        if (busy[k] === 1'b1) begin
          if (qsize(k) == 0) begin
            checks++;
            errors++;
            $display("FAIL mon%0d_extra_busy: got busy=1, want busy=0", k);
          end else begin
            e = pop(k);
            check($sformatf("mon%0d_line", k), {5'b0, dp[k], dm[k], done[k]}, {5'b0, e[2:0]});
            last_pop[k] = e[3];
          end
        end else begin
          check($sformatf("mon%0d_idle", k), {5'b0, dp[k], dm[k], done[k]}, 8'h4);
          if (busy_prev[k] === 1'b1)
            check($sformatf("mon%0d_pkt_end", k), {7'b0, last_pop[k]}, 8'h1);
        end
        busy_prev[k] = busy[k];
      end
    end
  end

  task automatic send(input int k, input logic [1:0] pt, input logic [127:0] pat,
                      input int abort_at, input int mid_at, input bit now);
    int   len = pkt_len(pt);
    int   n;
    int   idx = 0;
    int   cyc = 0;
    logic lvl = 1'b1;
    int   se0n = (k == 0) ? 2 : 3;
    int   jn = (k == 0) ? 1 : 4;
    n = (abort_at >= 0) ? abort_at : len;
    for (int i = 0; i < n; i++) begin
`ifdef DPDM_NRZI_EN
      lvl = pat[i] ? lvl : ~lvl;
`else
      lvl = pat[i];
`endif
      push(k, {(abort_at >= 0) && (i == n - 1), lvl, ~lvl, 1'b0});
    end
    if (abort_at < 0) begin
      for (int i = 0; i < se0n; i++) push(k, 4'b0000);
      for (int i = 0; i < jn - 1; i++) push(k, 4'b0100);
      push(k, 4'b1101);
    end
    if (!now) @(negedge clk);
    start[k]    = 1'b1;
    pkt_type[k] = pt;
    @(negedge clk);
    start[k]    = 1'b0;
    pkt_type[k] = 2'b00;
    while (cyc < 400) begin
      if (done[k] === 1'b1) break;
      if (bit_req[k] === 1'b1) begin
        if (idx == abort_at) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          break;
        end
        bit_in[k] = pat[idx];
        if (idx == mid_at) begin
          start[k]    = 1'b1;
          pkt_type[k] = 2'b10;
        end else begin
          start[k]    = 1'b0;
          pkt_type[k] = 2'b00;
        end
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    start[k] = 1'b0;
    if (abort_at >= 0) begin
      check("abort_line", {6'b0, dp[k], dm[k]}, 8'h2);
      check("abort_busy", {7'b0, busy[k]}, 8'h0);
      check("abort_bit_req", {7'b0, bit_req[k]}, 8'h0);
      check("abort_bits", idx[7:0], abort_at[7:0]);
      repeat (10) @(negedge clk);
    end else begin
      check($sformatf("done_seen%0d", k), {7'b0, done[k]}, 8'h1);
      check($sformatf("bit_req_count%0d", k), idx[7:0], len[7:0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start[k]    = 1'b0;
      pkt_type[k] = 2'b00;
      bit_in[k]   = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_line%0d", k), {6'b0, dp[k], dm[k]}, 8'h2);
      check($sformatf("rst_busy%0d", k), {7'b0, busy[k]}, 8'h0);
      check($sformatf("rst_done%0d", k), {7'b0, done[k]}, 8'h0);
      check($sformatf("rst_bit_req%0d", k), {7'b0, bit_req[k]}, 8'h0);
    end
    mon_en = 1'b1;

    send(0, 2'b01, {128{1'b1}}, -1, -1, 1'b0);                 // token, all ones
    send(0, 2'b11, {32{4'h5}}, -1, -1, 1'b0);                  // handshake, 1,0,1,0...
    send(0, 2'b10, 128'h0, -1, -1, 1'b0);                      // data, all zeros

    // Launch with pkt_type none is ignored.
    @(negedge clk);
    start[0] = 1'b1;
    pkt_type[0] = 2'b00;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("none_busy", {7'b0, busy[0]}, 8'h0);
    check("none_bit_req", {7'b0, bit_req[0]}, 8'h0);

    send(0, 2'b01, {128{1'b1}}, -1, 10, 1'b0);                 // start mid-token ignored
    send(0, 2'b11, 128'h0000_0000_0000_0000_0000_0000_0000_0a3c, -1, -1, 1'b0);
    send(0, 2'b01, 128'h0000_0000_0000_0000_0000_0000_c3a5_0f96, -1, -1, 1'b1); // start in done
    send(0, 2'b10, 128'h0000_0000_0000_0000_0000_0000_0012_d3b7, 20, -1, 1'b0); // abort
    send(1, 2'b11, {32{4'h5}}, -1, -1, 1'b0);                  // long EOP
    send(1, 2'b01, 128'h0000_0000_0000_0000_0000_0000_9e37_79b9, -1, -1, 1'b0);

    repeat (5) @(negedge clk);
    check("q0_empty", qsize(0)[7:0], 8'h0);
    check("q1_empty", qsize(1)[7:0], 8'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpdm_tx.md
DPDM_TX -- requirements
Module: dpdm_tx

Interface
REQ-001 SHALL have parameter TOK_BITS, default 32, meaning token packet length in bits including sync.
REQ-002 SHALL have parameter DATA_BITS, default 92, meaning data packet length in bits including sync.
REQ-003 SHALL have parameter HS_BITS, default 12, meaning handshake packet length in bits including sync.
REQ-004 SHALL have parameter EOP_SE0, default 2, meaning number of SE0 cycles in end-of-packet.
REQ-005 SHALL have parameter EOP_J, default 1, meaning number of J cycles after SE0 before idle.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: packet launch request.
REQ-009 SHALL have port pkt_type, input, 2 bits: 00 none, 01 token, 10 data, 11 handshake.
REQ-010 SHALL have port bit_in, input, 1 bit: next serial bit from encoder.
REQ-011 SHALL have port bit_req, output, 1 bit: bit_in is consumed this cycle.
REQ-012 SHALL have port busy, output, 1 bit: a packet or its EOP is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse at end of the final J cycle.
REQ-014 SHALL have ports dp and dm, outputs, 1 bit each: registered USB line pair.

Function
REQ-015 SHALL implement an FSM with states IDLE, DATA, SE0, EOPJ.
REQ-016 In IDLE, start=1 with pkt_type!=00 SHALL latch the length limit (TOK_BITS/DATA_BITS/HS_BITS) and enter DATA next cycle.
REQ-017 start with pkt_type=00, or start in any non-IDLE state, SHALL be ignored.
REQ-018 In DATA, bit_req SHALL be 1 every cycle, for exactly LIM cycles, then enter SE0.
REQ-019 A bit sampled with bit_req=1 SHALL appear on dp/dm on the following cycle (1-cycle latency).
REQ-020 Without NRZI, a driven bit b SHALL produce dp=b, dm=~b.
REQ-021 SE0 SHALL drive dp=0, dm=0 for exactly EOP_SE0 cycles, then enter EOPJ.
REQ-022 EOPJ SHALL drive dp=1, dm=0 for exactly EOP_J cycles, pulse done on the last, then return to IDLE.
REQ-023 IDLE SHALL drive J (dp=1, dm=0); busy SHALL be 1 in DATA, SE0, EOPJ only.
REQ-024 start SHALL be accepted in the cycle done is pulsed only after the FSM reaches IDLE (no back-to-back overlap); a new packet SHALL begin no earlier than one cycle after done.
REQ-025 The bit counter SHALL be sized ceil(log2(max(TOK_BITS,DATA_BITS,HS_BITS,EOP_SE0,EOP_J)+1)) bits and SHALL never wrap.
REQ-026 All parameters SHALL be >=1; values of 0 are illegal and an elaboration-time error.

Reset
REQ-027 rst=1 SHALL force state IDLE, counter 0, dp=1, dm=0, bit_req=0, busy=0, done=0 on the next edge.
REQ-028 rst asserted mid-packet SHALL abort without emitting EOP and without a done pulse.

Configuration
REQ-029 When DPDM_NRZI_EN is defined, DATA bits SHALL be NRZI encoded: bit 0 toggles the line, bit 1 holds it; line state SHALL start at J for each packet.
REQ-030 When DPDM_NRZI_EN is undefined, bits SHALL pass through per REQ-020 with no encoding state.

Structure
REQ-031 Package dpdm_pkg SHALL hold the pkt_type enum, FSM state enum, and default length constants 32/92/12.
REQ-032 FSM and counter SHALL live in sub-module dpdm_tx_fsm; the line-output/NRZI register SHALL live in dpdm_tx.

Verification
REQ-033 Token, no NRZI, bit_in=1 constant: start+pkt_type=01 -> bit_req high 32 cycles, dp=1/dm=0 for 32 cycles, 2 cycles SE0, 1 cycle J, done pulse; busy high 35 cycles.
REQ-034 Handshake, no NRZI, bit_in alternating 1,0: dp follows 1,0,... delayed 1 cycle for 12 cycles, then EOP.
REQ-035 NRZI_EN, data packet, bit_in=0 for 92 bits: dp toggles every cycle starting from K (dp=0) after first bit.
REQ-036 start with pkt_type=00, and start at cycle 10 of a running token: both ignored, no length change.
REQ-037 rst at cycle 20 of a data packet: next cycle dp=1, dm=0, busy=0, no SE0, no done.
REQ-038 EOP_SE0=3, EOP_J=4: SE0 lasts exactly 3 cycles, J exactly 4, done on the 4th J cycle.
